// File: rtl/mem_ctrl.sv
// Memory controller: serializes icache block refills and LSB loads/stores
// onto a byte-wide synchronous RAM port, one byte per cycle.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic [7:0]                    mem_din,
    output logic [7:0]                    mem_dout,
    output logic [ADDR_WIDTH-1:0]         mem_a,
    output logic                          mem_wr,
    input  logic                          IC2MC_en,
    input  logic [ADDR_WIDTH-1:0]         IC2MC_addr,
    output logic                          MC2IC_en,
    output logic [(32<<BLOCK_WIDTH)-1:0]  MC2IC_block,
    input  logic                          LSB2MC_en,
    input  logic                          LSB2MC_wr,
    input  logic [1:0]                    LSB2MC_len,
    input  logic [ADDR_WIDTH-1:0]         LSB2MC_addr,
    input  logic [31:0]                   LSB2MC_data,
    output logic                          MC2LSB_en,
    output logic [31:0]                   MC2LSB_data,
    input  logic                          ROB2MC_pre_judge
);

    localparam int unsigned BLK_BYTES = 4 << BLOCK_WIDTH;
    localparam int unsigned BLK_W     = 32 << BLOCK_WIDTH;
    localparam int unsigned CNT_W     = $clog2(BLK_BYTES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        IFETCH,
        LOAD,
        STORE,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   last;
    logic [31:0]        st_data;
    logic [BLK_W-1:0]   rd_buf;

    logic [CNT_W-1:0]   cnt_inc_c;
    logic [CNT_W-1:0]   lsb_last_c;
    logic [BLK_W-1:0]   rd_next_c;

    // Next byte index, LSB access length, and read buffer with the current byte merged in
    always_comb begin
        cnt_inc_c = cnt + CNT_W'(1);
        rd_next_c = rd_buf | (BLK_W'(mem_din) << {cnt, 3'b000});
        case (LSB2MC_len)
            2'd0:    lsb_last_c = CNT_W'(0);
            2'd1:    lsb_last_c = CNT_W'(1);
            default: lsb_last_c = CNT_W'(3);
        endcase
    end

    // Request arbitration, byte sequencing and registered RAM/response outputs
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= '0;
            st_data     <= '0;
            rd_buf      <= '0;
            mem_a       <= '0;
            mem_dout    <= '0;
            mem_wr      <= 1'b0;
            MC2IC_en    <= 1'b0;
            MC2IC_block <= '0;
            MC2LSB_en   <= 1'b0;
            MC2LSB_data <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (LSB2MC_en) begin
                        mem_a   <= LSB2MC_addr;
                        cnt     <= '0;
                        last    <= lsb_last_c;
                        st_data <= LSB2MC_data;
                        rd_buf  <= '0;
                        if (LSB2MC_wr) begin
                            mem_wr   <= 1'b1;
                            mem_dout <= LSB2MC_data[7:0];
                            state    <= STORE;
                        end else begin
                            mem_wr <= 1'b0;
                            state  <= LOAD;
                        end
                    end else if (IC2MC_en && ROB2MC_pre_judge) begin
                        mem_a  <= IC2MC_addr;
                        cnt    <= '0;
                        last   <= CNT_W'(BLK_BYTES - 1);
                        rd_buf <= '0;
                        mem_wr <= 1'b0;
                        state  <= IFETCH;
                    end
                end
                IFETCH: begin
                    if (!ROB2MC_pre_judge) begin
                        mem_wr <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == last) begin
                        MC2IC_block <= rd_next_c;
                        MC2IC_en    <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rd_buf <= rd_next_c;
                        cnt    <= cnt_inc_c;
                        mem_a  <= mem_a + ADDR_WIDTH'(1);
                    end
                end
                LOAD: begin
                    if (cnt == last) begin
                        MC2LSB_data <= rd_next_c[31:0];
                        MC2LSB_en   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rd_buf <= rd_next_c;
                        cnt    <= cnt_inc_c;
                        mem_a  <= mem_a + ADDR_WIDTH'(1);
                    end
                end
                STORE: begin
                    if (cnt == last) begin
                        mem_wr    <= 1'b0;
                        MC2LSB_en <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt      <= cnt_inc_c;
                        mem_a    <= mem_a + ADDR_WIDTH'(1);
                        mem_dout <= 8'(st_data >> {cnt_inc_c, 3'b000});
                    end
                end
                DONE: begin
                    MC2IC_en  <= 1'b0;
                    MC2LSB_en <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller: the responder side of the instruction-cache refill interface (IC2MC/MC2IC) and of the load/store buffer interface (LSB2MC/MC2LSB).
- Serializes every request onto the byte-wide synchronous RAM port.
- IC requests are always 2-word (64-bit) block refills. LSB requests are 1/2/4-byte loads or stores.
- Sits between icache/LSB and the top-level RAM pins.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- BLOCK_WIDTH, 1, log2 of words per IC block; IC refill length is 4<<BLOCK_WIDTH bytes (8).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous, active-low reset.
- rdy_in  in  1  global ready; low freezes the block.
- mem_din  in  8  RAM read data; valid the cycle after the address is driven.
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  1=write, 0=read.
- IC2MC_en  in  1  IC refill request; held high by IC until MC2IC_en.
- IC2MC_addr  in  ADDR_WIDTH  block-aligned refill base address.
- MC2IC_en  out  1  one-cycle refill-done pulse.
- MC2IC_block  out  32<<BLOCK_WIDTH  refill data, little-endian.
- LSB2MC_en  in  1  LSB request; held high until MC2LSB_en.
- LSB2MC_wr  in  1  1=store, 0=load.
- LSB2MC_len  in  2  0=byte, 1=half, 2=word (3 treated as word).
- LSB2MC_addr  in  ADDR_WIDTH  byte address.
- LSB2MC_data  in  32  store data; low bytes used.
- MC2LSB_en  out  1  one-cycle done pulse.
- MC2LSB_data  out  32  load data, zero-extended.
- ROB2MC_pre_judge  in  1  0 = misprediction flush this cycle.

Behaviour:
- States: IDLE, IFETCH, LOAD, STORE, DONE.
- Reset: when rst_in=0 at an edge, the block goes to IDLE. mem_a, mem_dout, mem_wr, MC2IC_en, MC2IC_block, MC2LSB_en and MC2LSB_data are all cleared to 0. A reset mid-operation aborts it with no done pulse.
- rdy_in=0: every register holds, including mem_a and mem_wr. rst_in still takes priority over rdy_in.
- Accept (IDLE, edge E0):
  - LSB2MC_en has priority over IC2MC_en.
  - n = 8 for IC, 1/2/4 for LSB.
  - At E0: mem_a <= base, byte counter <= 0, state <= IFETCH/LOAD/STORE.
- Sequencing: byte k (k = 0..n-1) is driven on mem_a = base+k during the cycle after edge Ek. Address arithmetic wraps mod 2^ADDR_WIDTH.
- Read (IFETCH/LOAD):
  - mem_wr = 0.
  - mem_din for byte k is captured at edge E(k+1) into bits [8k+7:8k].
  - At En, the output data register is written including the last byte, the done pulse is set, and state <= DONE.
  - Read latency is n cycles from accept: 8 for IC, 4 for a word load.
- Store:
  - During the cycle after Ek: mem_wr = 1, mem_dout = LSB2MC_data[8k+7:8k].
  - At En: mem_wr <= 0, MC2LSB_en <= 1, state <= DONE.
- DONE:
  - Lasts exactly one cycle. Done pulses drop at its end, and state returns to IDLE.
  - Requests are ignored in DONE, because the requester is still holding its en that cycle.
- mem_wr is 0 in every state except STORE.
- Flush (ROB2MC_pre_judge=0 at an edge):
  - In IFETCH: abort, state <= IDLE, no MC2IC_en, mem_wr <= 0.
  - In IDLE: IC2MC_en is ignored that edge, but LSB2MC_en may still be accepted.
  - LOAD, STORE and DONE are unaffected.
- Simultaneous LSB and IC requests in IDLE: LSB is served first. IC stays pending and is accepted in the IDLE cycle after the LSB's DONE.
- MC2IC_block and MC2LSB_data hold their last value until the next completion of the same kind.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles mid-IFETCH -> all outputs 0, no MC2IC_en. After release and an IC request at 0x1000 with RAM[0x1000..7]=01..08 -> MC2IC_en pulses 8 cycles after accept with MC2IC_block=0x0807060504030201, and exactly one pulse.
- Word load at 0x20 (RAM 0xEF,0xBE,0xAD,0xDE) -> MC2LSB_data=0xDEADBEEF after 4 cycles. Half load at 0x22 -> 0x0000DEAD. Byte load -> zero-extended.
- Word store 0xCAFEBABE to 0x40 -> mem_wr=1 for exactly 4 consecutive cycles, mem_a=0x40..0x43, mem_dout=BE,BA,FE,CA. MC2LSB_en follows. Reading back returns 0xCAFEBABE.
- IC and LSB requests raised in the same cycle -> LSB completes first. IC is then accepted in the IDLE cycle after the LSB's DONE and completes 8 cycles later. Each requester gets exactly one pulse.
- ROB2MC_pre_judge=0 at the 3rd byte of an IFETCH -> no MC2IC_en, mem_wr stays 0, state IDLE. A new IC request afterwards completes normally. A flush during a STORE does not alter its 4 writes.
- rdy_in=0 for 5 cycles mid-LOAD, with the RAM stalled equally -> same data, latency extended by 5 cycles. Also an IC refill at base 0xFFFFFFF8 -> mem_a runs to 0xFFFFFFFF with no overflow artefacts.
